// File: rtl/evr_log_pkg.sv
// Shared state encoding and logger CSR field positions for the EVR log drain.
package evr_log_pkg;

    typedef enum logic [2:0] {
        StRstop,
        StIdle,
        StArm,
        StPoll,
        StAddr,
        StWait,
        StPush,
        StHalt
    } drainState_e;

    localparam int unsigned RUN_BIT   = 31;
    localparam int unsigned EVENT_LSB = 16;
    localparam int unsigned EVENT_MSB = 23;

    function automatic logic [31:0] ctrlWord(input logic run, input logic [30:0] addr);
        return {run, addr};
    endfunction

endpackage

// File: rtl/evr_log_ptr_stable.sv
// Double-sample agreement filter for the logger write pointer arriving from another domain.
module evr_log_ptr_stable #(
    parameter int unsigned WIDTH = 10
) (
    input  logic             sysClk,
    input  logic             sysReset,
    input  logic [WIDTH-1:0] rawPtr,
    output logic [WIDTH-1:0] stablePtr
);

    logic [WIDTH-1:0] sampleQ;
    logic [WIDTH-1:0] stableQ;

    always_ff @(posedge sysClk) begin
        if (sysReset) begin
            sampleQ <= '0;
            stableQ <= '0;
        end else begin
            sampleQ <= rawPtr;
            if (rawPtr == sampleQ) begin
                stableQ <= rawPtr;
            end
        end
    end

    assign stablePtr = stableQ;

endmodule

// File: rtl/evr_log_drain.sv
// Readout controller for the EVR event logger: arms/stops the logger and streams logged entries.
// Define EVR_LOG_DRAIN_DELTA_EN to emit tick deltas between entries instead of absolute stamps.
module evr_log_drain
    import evr_log_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH = 10,
    parameter int unsigned HEADROOM   = 4
) (
    input  logic                  sysClk,
    input  logic                  sysReset,
    input  logic                  cmdStart,
    input  logic                  cmdStop,
    output logic                  logCsrStrobe,
    output logic [31:0]           logGpioOut,
    input  logic [31:0]           logCsr,
    input  logic [31:0]           logDataTicks,
    output logic                  outValid,
    input  logic                  outReady,
    output logic [7:0]            outEvent,
    output logic [31:0]           outTicks,
    output logic                  busy,
    output logic                  overflow,
    output logic [ADDR_WIDTH-1:0] pending
);

    localparam logic [ADDR_WIDTH-1:0] LAP_LIMIT = ADDR_WIDTH'((1 << ADDR_WIDTH) - HEADROOM);

    drainState_e           stateQ, stateD;
    logic [ADDR_WIDTH-1:0] rdPtrQ, rdPtrD, wrStable, pendCalc, pendingQ;
    logic                  waitQ, waitD, stopPendQ, stopPendD, overflowQ, overflowD, busyQ;
    logic [31:0]           gpioQ, gpioD, ticksQ, ticksNext;
    logic [7:0]            eventQ;
    logic                  capture, handshake, newSession;
    logic                  unusedCsr;

    evr_log_ptr_stable #(
        .WIDTH(ADDR_WIDTH)
    ) uPtrStable (
        .sysClk   (sysClk),
        .sysReset (sysReset),
        .rawPtr   (logCsr[ADDR_WIDTH-1:0]),
        .stablePtr(wrStable)
    );

    assign pendCalc  = wrStable - rdPtrQ;
    assign unusedCsr = ^logCsr;

    always_comb begin
        stateD     = stateQ;
        rdPtrD     = rdPtrQ;
        waitD      = waitQ;
        stopPendD  = stopPendQ;
        overflowD  = overflowQ;
        gpioD      = gpioQ;
        capture    = 1'b0;
        handshake  = 1'b0;
        newSession = 1'b0;
        unique case (stateQ)
            StRstop: stateD = StIdle;
            StIdle: begin
                if (cmdStart && !cmdStop) begin
                    stateD     = StArm;
                    overflowD  = 1'b0;
                    rdPtrD     = '0;
                    newSession = 1'b1;
                end
            end
            StArm: stateD = cmdStop ? StHalt : StPoll;
            StPoll: begin
                if (cmdStop) begin
                    stateD = StHalt;
                end else if (pendCalc >= LAP_LIMIT) begin
                    overflowD = 1'b1;
                    stateD    = StHalt;
                end else if (pendCalc != '0) begin
                    stateD = StAddr;
                end
            end
            StAddr: begin
                waitD  = 1'b0;
                stateD = cmdStop ? StHalt : StWait;
            end
            StWait: begin
                if (cmdStop) begin
                    stateD = StHalt;
                end else if (waitQ) begin
                    capture = 1'b1;
                    stateD  = StPush;
                end else begin
                    waitD = 1'b1;
                end
            end
            StPush: begin
                // A stop seen mid-handshake is remembered so the entry still goes out.
                if (cmdStop) begin
                    stopPendD = 1'b1;
                end
                if (outReady) begin
                    handshake = 1'b1;
                    rdPtrD    = rdPtrQ + 1'b1;
                    stopPendD = 1'b0;
                    stateD    = (stopPendQ || cmdStop) ? StHalt : StPoll;
                end
            end
            StHalt: begin
                stopPendD = 1'b0;
                stateD    = StIdle;
            end
            default: stateD = StIdle;
        endcase

        case (stateD)
            StArm:   gpioD = ctrlWord(1'b1, '0);
            StAddr:  gpioD = ctrlWord(1'b1, 31'(rdPtrD));
            StHalt:  gpioD = ctrlWord(1'b0, 31'(rdPtrD));
            default: gpioD = gpioQ;
        endcase
    end

`ifdef EVR_LOG_DRAIN_DELTA_EN
    logic [31:0] prevTicksQ, rawTicksQ;
    logic        firstQ;

    always_ff @(posedge sysClk) begin
        if (sysReset) begin
            prevTicksQ <= '0;
            rawTicksQ  <= '0;
            firstQ     <= 1'b0;
        end else begin
            if (newSession) begin
                prevTicksQ <= '0;
                firstQ     <= 1'b1;
            end
            if (capture) begin
                rawTicksQ <= logDataTicks;
            end
            if (handshake) begin
                prevTicksQ <= rawTicksQ;
                firstQ     <= 1'b0;
            end
        end
    end

    assign ticksNext = firstQ ? '0 : logDataTicks - prevTicksQ;
`else
    assign ticksNext = logDataTicks;
`endif

    always_ff @(posedge sysClk) begin
        if (sysReset) begin
            stateQ    <= StRstop;
            rdPtrQ    <= '0;
            waitQ     <= 1'b0;
            stopPendQ <= 1'b0;
            overflowQ <= 1'b0;
            gpioQ     <= '0;
            eventQ    <= '0;
            ticksQ    <= '0;
            pendingQ  <= '0;
            busyQ     <= 1'b0;
        end else begin
            stateQ    <= stateD;
            rdPtrQ    <= rdPtrD;
            waitQ     <= waitD;
            stopPendQ <= stopPendD;
            overflowQ <= overflowD;
            gpioQ     <= gpioD;
            pendingQ  <= pendCalc;
            busyQ     <= (stateD != StIdle);
            if (capture) begin
                eventQ <= logCsr[EVENT_MSB:EVENT_LSB];
                ticksQ <= ticksNext;
            end
        end
    end

    // Gated by reset so the stop strobe only appears once reset has been released.
    assign logCsrStrobe = ~sysReset & (stateQ inside {StRstop, StArm, StAddr, StHalt});
    assign logGpioOut   = gpioQ;
    assign outValid     = (stateQ == StPush);
    assign outEvent     = eventQ;
    assign outTicks     = ticksQ;
    assign busy         = busyQ;
    assign overflow     = overflowQ;
    assign pending      = pendingQ;

endmodule

// File: tb/tb_evr_log_drain.sv
// Self-checking bench for evr_log_drain with a behavioural logger model and an expected-entry queue.
module tb_evr_log_drain;

    localparam int unsigned AW = 10;
`ifdef EVR_LOG_DRAIN_DELTA_EN
    localparam bit DeltaEn = 1'b1;
`else
    localparam bit DeltaEn = 1'b0;
`endif

    typedef struct {
        logic [7:0]  evt;
        logic [31:0] ticks;
        logic [7:0]  expEvt;
        logic [31:0] expTicks;
    } vec_t;

    typedef struct {
        logic [7:0]  evt;
        logic [31:0] ticks;
    } exp_t;

    logic sysClk = 1'b0;
    always #5 sysClk = ~sysClk;

    logic          sysReset, cmdStart, cmdStop, outReady;
    logic          logCsrStrobe, outValid, busy, overflow;
    logic [31:0]   logGpioOut, logCsr, logDataTicks, outTicks;
    logic [7:0]    outEvent;
    logic [AW-1:0] pending;

    logic        sStart, sStop, sReady, sStrobe, sValid, sBusy, sOverflow;
    logic [31:0] sGpio, sCsr, sTicksIn, sTicksOut;
    logic [7:0]  sEvent;
    logic [3:0]  sPending, sWr;

    // Logger model: address register then data register, both loaded from the strobe.
    logic [7:0]    memEvt [1024];
    logic [31:0]   memTicks [1024];
    logic [AW-1:0] wrPtr, addrReg;
    logic [7:0]    evtReg;
    logic [31:0]   dataReg;
    logic          runReg = 1'b1;

    always @(posedge sysClk) begin
        if (logCsrStrobe) begin
            addrReg <= logGpioOut[AW-1:0];
            runReg  <= logGpioOut[31];
        end
        evtReg  <= memEvt[addrReg];
        dataReg <= memTicks[addrReg];
    end

    assign logCsr       = {runReg, 7'b0, evtReg, 6'b0, wrPtr};
    assign logDataTicks = dataReg;
    assign sCsr         = {28'b0, sWr};
    assign sTicksIn     = 32'd0;

    evr_log_drain #(.ADDR_WIDTH(AW), .HEADROOM(4)) dut (
        .sysClk(sysClk), .sysReset(sysReset), .cmdStart(cmdStart), .cmdStop(cmdStop),
        .logCsrStrobe(logCsrStrobe), .logGpioOut(logGpioOut), .logCsr(logCsr),
        .logDataTicks(logDataTicks), .outValid(outValid), .outReady(outReady),
        .outEvent(outEvent), .outTicks(outTicks), .busy(busy), .overflow(overflow),
        .pending(pending)
    );

    evr_log_drain #(.ADDR_WIDTH(4), .HEADROOM(4)) dutSmall (
        .sysClk(sysClk), .sysReset(sysReset), .cmdStart(sStart), .cmdStop(sStop),
        .logCsrStrobe(sStrobe), .logGpioOut(sGpio), .logCsr(sCsr),
        .logDataTicks(sTicksIn), .outValid(sValid), .outReady(sReady),
        .outEvent(sEvent), .outTicks(sTicksOut), .busy(sBusy), .overflow(sOverflow),
        .pending(sPending)
    );

    int   vectors = 0;
    int   miscompares = 0;
    vec_t tbl [6];
    exp_t expQ [$];

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
        vectors++;
        if (got !== want) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h, required 0x%0h", name, got, want);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge sysClk);
    endtask

    task automatic logEntry(input int i);
        exp_t e;
        memEvt[wrPtr]   = tbl[i].evt;
        memTicks[wrPtr] = tbl[i].ticks;
        wrPtr           = wrPtr + 1'b1;
        e.evt           = tbl[i].expEvt;
        e.ticks         = tbl[i].expTicks;
        expQ.push_back(e);
    endtask

    task automatic waitValid(input string name, input int budget);
        int cyc = 0;
        while (!outValid && cyc < budget) begin
            @(negedge sysClk);
            cyc++;
        end
        check(name, outValid, 1);
    endtask

    task automatic drain(input int n, input int budget);
        int   left = n;
        int   cyc = 0;
        exp_t e;
        while (left > 0 && cyc < budget) begin
            if (outValid && outReady) begin
                if (expQ.size() == 0) begin
                    check("unexpected entry", outValid, 0);
                end else begin
                    e = expQ.pop_front();
                    check("entry event", outEvent, e.evt);
                    check("entry ticks", outTicks, e.ticks);
                end
                left--;
            end
            @(negedge sysClk);
            cyc++;
        end
        if (left > 0) check("drain timeout", left, 0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: bench did not finish, required completion");
        $fatal(1);
    end

    initial begin
        int lat;
        int bad;
        int seen;

        tbl[0] = '{8'h70, 32'd1000, 8'h70, DeltaEn ? 32'd0 : 32'd1000};
        tbl[1] = '{8'h7D, 32'd1250, 8'h7D, DeltaEn ? 32'd250 : 32'd1250};
        tbl[2] = '{8'h11, 32'd1300, 8'h11, DeltaEn ? 32'd50 : 32'd1300};
        tbl[3] = '{8'h22, 32'd5000, 8'h22, DeltaEn ? 32'd3700 : 32'd5000};
        tbl[4] = '{8'h33, 32'd5001, 8'h33, DeltaEn ? 32'd1 : 32'd5001};
        tbl[5] = '{8'h44, 32'd16, 8'h44, DeltaEn ? 32'hFFFF_EC87 : 32'd16};

        sysReset = 1'b1; cmdStart = 1'b0; cmdStop = 1'b0; outReady = 1'b0;
        sStart = 1'b0; sStop = 1'b0; sReady = 1'b0; sWr = '0; wrPtr = '0;
        tick(3);
        check("reset strobe", logCsrStrobe, 0);
        check("reset gpio", logGpioOut, 0);
        check("reset valid", outValid, 0);
        check("reset event", outEvent, 0);
        check("reset ticks", outTicks, 0);
        check("reset busy", busy, 0);
        check("reset overflow", overflow, 0);
        check("reset pending", pending, 0);

        sysReset = 1'b0;
        #1;
        check("rstop strobe", logCsrStrobe, 1);
        check("rstop gpio", logGpioOut, 32'h0);
        tick(1);
        check("logger stopped", runReg, 0);
        check("idle strobe", logCsrStrobe, 0);
        check("idle busy", busy, 0);

        // Two entries, consumer always ready.
        outReady = 1'b1;
        cmdStart = 1'b1;
        tick(1);
        cmdStart = 1'b0;
        check("arm strobe", logCsrStrobe, 1);
        check("arm gpio", logGpioOut, 32'h8000_0000);
        tick(3);
        logEntry(0);
        lat = 0;
        while (!outValid && lat < 20) begin
            @(negedge sysClk);
            lat++;
        end
        check("first latency", lat, 6);
        drain(1, 40);
        logEntry(1);
        drain(1, 40);

        // Three entries held back by a stalled consumer.
        outReady = 1'b0;
        logEntry(2);
        tick(1);
        logEntry(3);
        tick(1);
        logEntry(4);
        waitValid("stall valid", 30);
        bad = 0;
        for (int c = 0; c < 20; c++) begin
            if (!outValid || outEvent !== expQ[0].evt || outTicks !== expQ[0].ticks) bad++;
            tick(1);
        end
        check("stall steady", bad, 0);
        check("stall pending", pending, 3);
        outReady = 1'b1;
        drain(3, 60);

        // Stop while an entry is being offered.
        outReady = 1'b0;
        logEntry(5);
        waitValid("stop valid", 30);
        cmdStop = 1'b1;
        tick(1);
        cmdStop = 1'b0;
        tick(2);
        check("stop holds valid", outValid, 1);
        outReady = 1'b1;
        drain(1, 5);
        seen = 0;
        while (!logCsrStrobe && seen < 4) begin
            tick(1);
            seen++;
        end
        check("halt strobe", logCsrStrobe, 1);
        check("halt gpio", logGpioOut, 32'h0000_0006);
        tick(1);
        check("halt busy", busy, 0);
        check("halt logger run", runReg, 0);
        wrPtr = '0;

        // Write pointer glitching must not move the stable copy.
        wrPtr = 10'd3;
        tick(3);
        check("glitch settle", dut.wrStable, 3);
        for (int k = 0; k < 8; k++) begin
            wrPtr = (k % 2 == 1) ? 10'd7 : 10'd5;
            tick(1);
        end
        check("glitch hold", dut.wrStable, 3);
        tick(2);
        check("glitch accept", dut.wrStable, 7);
        wrPtr = '0;
        tick(3);

        // Start and stop together in idle: stop wins.
        cmdStart = 1'b1;
        cmdStop  = 1'b1;
        tick(1);
        cmdStart = 1'b0;
        cmdStop  = 1'b0;
        seen = 0;
        for (int c = 0; c < 4; c++) begin
            if (logCsrStrobe || busy) seen++;
            tick(1);
        end
        check("start+stop ignored", seen, 0);

        // Small instance: write pointer jumps into the headroom zone.
        sStart = 1'b1;
        tick(1);
        sStart = 1'b0;
        tick(2);
        sWr = 4'd12;
        seen = 0;
        while (!sStrobe && seen < 10) begin
            tick(1);
            seen++;
        end
        check("ovf halt strobe", sStrobe, 1);
        check("ovf halt gpio", sGpio, 32'h0);
        check("ovf pending", sPending, 12);
        tick(1);
        check("ovf flag", sOverflow, 1);
        check("ovf busy", sBusy, 0);
        sWr = 4'd0;
        tick(3);
        sStart = 1'b1;
        tick(1);
        sStart = 1'b0;
        check("ovf cleared by start", sOverflow, 0);
        sStop = 1'b1;
        tick(1);
        sStop = 1'b0;
        tick(2);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/evr_log_drain.md
# evr_log_drain

Single-clock readout controller for the EVR event logger: arms and stops the logger through its CSR/GPIO port, tracks the logger write pointer, walks the read address, and delivers each logged entry (event code and tick stamp) as a valid/ready stream. It sits in the system clock domain between the logger and the software-facing event FIFO. Software issues start/stop and never drives the logger port directly.

## Interface
- ADDR_WIDTH, 10, logger DPRAM address width (must match logger)
- HEADROOM, 4, free slots below which the logger is considered about to lap the reader
- sysClk  in  1  system clock; only clock
- sysReset  in  1  reset is synchronous and active-high
- cmdStart  in  1  one-cycle pulse: arm logger and begin draining
- cmdStop  in  1  one-cycle pulse: stop logging and return to idle
- logCsrStrobe  out  1  write strobe to logger control register
- logGpioOut  out  32  logger control word: bit31 running, [ADDR_WIDTH-1:0] read address
- logCsr  in  32  logger status: bit31 running, [23:16] event at read address, [ADDR_WIDTH-1:0] write pointer
- logDataTicks  in  32  tick stamp at read address
- outValid  out  1  entry available
- outReady  in  1  consumer accepts entry
- outEvent  out  8  event code
- outTicks  out  32  tick stamp (absolute or delta, see Configuration)
- busy  out  1  not in IDLE
- overflow  out  1  sticky; set when headroom violated, cleared by cmdStart
- pending  out  ADDR_WIDTH  entries logged but not yet delivered

## Operation
- States: RSTOP, IDLE, ARM, POLL, ADDR, WAIT, PUSH, HALT.
- RSTOP: first cycle after reset; strobe with logGpioOut = 0 so a logger left running is stopped; then IDLE.
- IDLE: cmdStart -> ARM; clear overflow, rdPtr = 0, prevTicks = 0.
- ARM: strobe {running=1, addr=0} -> POLL.
- POLL: write pointer crosses clock domains; sample logCsr[ADDR_WIDTH-1:0] every cycle, accept into wrStable only when two consecutive samples agree. pending = wrStable − rdPtr mod 2^ADDR_WIDTH. pending ≥ 2^ADDR_WIDTH − HEADROOM -> set overflow, HALT. pending ≠ 0 -> ADDR; else remain.
- ADDR: strobe {1, rdPtr} -> WAIT.
- WAIT: two cycles (logger address register, then data register) -> PUSH, capturing logCsr[23:16] and logDataTicks into output registers on entry.
- PUSH: outValid=1, outputs stable until outValid && outReady; then rdPtr++ (wraps at 2^ADDR_WIDTH) -> POLL.
- HALT: strobe {running=0, addr=rdPtr} -> IDLE. Logger clears its write pointer after its own synchronizer.
- cmdStop in POLL/ADDR/WAIT -> HALT next cycle; in PUSH, finish current handshake, then HALT; in IDLE ignored.
- cmdStart outside IDLE ignored; simultaneous cmdStart and cmdStop: stop wins.

## Timing
- Reset values: logCsrStrobe 0, logGpioOut 0, outValid 0, outEvent 0, outTicks 0, busy 0, overflow 0, pending 0. First cycle after reset: logCsrStrobe=1 (RSTOP).
- logCsrStrobe is a single-cycle pulse; logGpioOut valid in the same cycle and held until the next strobe.
- Latency from an accepted wrStable change to outValid: ADDR 1 + WAIT 2 + PUSH = outValid on 4th cycle after leaving POLL.
- Sustained throughput with outReady tied high: one entry per 5 cycles.
- pending updates registered, one cycle after wrStable/rdPtr change.
- outValid never deasserts without a handshake except on sysReset.
- Reset mid-PUSH drops the entry; RSTOP then stops the logger.

## Configuration
- EVR_LOG_DRAIN_DELTA_EN defined: outTicks = logDataTicks − prevTicks mod 2^32, prevTicks updated on each handshake; first entry after cmdStart outputs 0.
- Undefined: outTicks = logDataTicks unmodified; prevTicks register absent.

## Structure
- Package evr_log_pkg: state enum, logger CSR bit positions (RUN_BIT = 31, EVENT_LSB = 16, EVENT_MSB = 23).
- One sub-module: evr_log_ptr_stable (double-sample agreement filter, width ADDR_WIDTH).

## Test plan
- Reset with logger model running -> one strobe with logGpioOut = 0x00000000, then IDLE, all outputs 0.
- cmdStart, model logs events 0x70 @ 1000, 0x7D @ 1250; outReady=1 -> outputs (0x70,1000), (0x7D,1250); delta build gives (0x70,0), (0x7D,250).
- outReady held low 20 cycles with 3 entries pending -> outValid steady, outputs unchanged, pending = 3, then drains in order.
- Write pointer glitching between 5 and 7 on alternate cycles -> wrStable unchanged until two equal samples.
- ADDR_WIDTH=4, HEADROOM=4, 12 entries logged with outReady=0 -> overflow=1, stop strobe bit31=0, busy=0.
- Same-cycle cmdStart+cmdStop in IDLE -> stays IDLE; cmdStop during PUSH -> current entry delivered, then halt strobe.
